// File: rtl/sdiv_pkg.sv
// sdiv_pkg -- shared types and constants for the signed sequential divider.
//   sdiv_state_e : FSM state encoding (IDLE, CALC, FIX, DONE)
//   SDIV_DW      : default dividend / quotient width
//   SDIV_VW      : default divisor / remainder width
//   SDIV_CW      : iteration counter width for the default dividend width
//   sdiv_cnt_w() : counter width for an arbitrary dividend width
package sdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } sdiv_state_e;

  localparam int SDIV_DW = 8;
  localparam int SDIV_VW = 4;
  localparam int SDIV_CW = $clog2(SDIV_DW);

  // The counter holds DW-1 down to 0, so $clog2(DW) bits suffice (DW >= 2).
  function automatic int sdiv_cnt_w(input int dw);
    return $clog2(dw);
  endfunction

endpackage

// File: rtl/sdiv_restoring_step.sv
// sdiv_restoring_step -- one iteration of restoring division on magnitudes.
// Purely combinational.
//   i_rem  : current partial remainder (VW+1 bits, unsigned)
//   i_bit  : next dividend bit shifted in from the MSB side
//   i_dmag : divisor magnitude (VW+1 bits, unsigned)
//   o_rem  : next partial remainder
//   o_q    : quotient bit produced by this iteration
module sdiv_restoring_step #(
  parameter int VW = 4
) (
  input  logic [VW:0] i_rem,
  input  logic        i_bit,
  input  logic [VW:0] i_dmag,
  output logic [VW:0] o_rem,
  output logic        o_q
);

  logic [VW+1:0] w_shift;
  logic [VW:0]   w_diff;

  assign w_shift = {i_rem, i_bit};
  // The full-width compare decides the quotient bit; the subtraction only
  // needs the low bits because a kept result is always below |divisor|.
  assign o_q     = (w_shift >= {1'b0, i_dmag});
  assign w_diff  = w_shift[VW:0] - i_dmag;
  assign o_rem   = o_q ? w_diff : w_shift[VW:0];

endmodule

// File: rtl/signed_seq_divider.sv
// signed_seq_divider -- multi-cycle signed divider (restoring, 1 bit/clock).
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Optional build macro: SDIV_DIVZERO_FAST_EN -- when defined, a zero divisor
// skips the CALC/FIX sequence and completes one cycle after acceptance.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   dividend [DW], divisor [VW] : signed operands
//   out_valid / out_ready : result handshake (result held until taken)
//   quotient [DW], remainder [VW] : signed results
//   div_zero, ovf         : divide-by-zero and -2^(DW-1)/-1 overflow flags
module signed_seq_divider
  import sdiv_pkg::*;
#(
  parameter int DW = SDIV_DW,
  parameter int VW = SDIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero,
  output logic          ovf
);

  localparam int CW = sdiv_cnt_w(DW);

  sdiv_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dvd;       // dividend magnitude, becomes quotient magnitude
  logic [VW:0]   r_dmag;      // divisor magnitude
  logic [VW:0]   r_rem;       // partial remainder
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dz;
  logic          r_ovf_case;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_rem_o;
  logic          r_div_zero;
  logic          r_ovf;

  logic [DW-1:0] w_dvd_mag;
  logic [VW-1:0] w_dsr_mag;
  logic          w_dz;
  logic          w_ovf_case;
  logic [VW:0]   w_rem_next;
  logic          w_q_bit;

  // Two's-complement negation at native width yields the correct unsigned
  // magnitude even for the most negative value (e.g. -128 -> 8'h80).
  assign w_dvd_mag  = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
  assign w_dsr_mag  = divisor[VW-1]  ? (~divisor  + 1'b1) : divisor;
  assign w_dz       = (divisor == '0);
  assign w_ovf_case = (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);

  sdiv_restoring_step #(.VW(VW)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[DW-1]),
    .i_dmag (r_dmag),
    .o_rem  (w_rem_next),
    .o_q    (w_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dmag      <= '0;
      r_rem       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_ovf_case  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem_o     <= '0;
      r_div_zero  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            r_neg_q    <= dividend[DW-1] ^ divisor[VW-1];
            r_neg_r    <= dividend[DW-1];
            r_dz       <= w_dz;
            r_ovf_case <= w_ovf_case;
            r_dvd      <= w_dvd_mag;
            r_dmag     <= {1'b0, w_dsr_mag};
            r_rem      <= '0;
            r_cnt      <= CW'(DW - 1);
`ifdef SDIV_DIVZERO_FAST_EN
            if (w_dz) begin
              r_quot      <= '1;
              r_rem_o     <= '0;
              r_div_zero  <= 1'b1;
              r_ovf       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state     <= ST_CALC;
            end
`else
            r_state    <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[DW-2:0], w_q_bit};
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_FIX: begin
          if (r_dz) begin
            r_quot     <= '1;
            r_rem_o    <= '0;
            r_div_zero <= 1'b1;
            r_ovf      <= 1'b0;
          end else begin
            // The overflow case wraps naturally: |q| = 2^(DW-1), and its
            // negation (if any) is the same bit pattern; remainder is 0.
            r_quot     <= r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
            r_rem_o    <= r_neg_r ? (~r_rem[VW-1:0] + 1'b1) : r_rem[VW-1:0];
            r_div_zero <= 1'b0;
            r_ovf      <= r_ovf_case;
          end
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign quotient  = r_quot;
  assign remainder = r_rem_o;
  assign div_zero  = r_div_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider -- directed, table-driven bench for signed_seq_divider.
// Latency is counted in clock edges including the accepting edge, so a
// result appearing after edge T+DW+1 counts as 10 for DW=8.
module tb_signed_seq_divider;

  localparam int DW    = 8;
  localparam int VW    = 4;
  localparam int LAT_N = 10;
`ifdef SDIV_DIVZERO_FAST_EN
  localparam int LAT_Z = 1;
`else
  localparam int LAT_Z = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;
  logic          ovf;

  signed_seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dvd;
    int dsr;
    int q;
    int r;
    int dz;
    int ov;
    int lat;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sq();
    return int'($signed(quotient));
  endfunction

  function automatic int sr();
    return int'($signed(remainder));
  endfunction

  // Present operands, count cycles to out_valid; result is left pending.
  task automatic start_and_wait(input int dvd, input int dsr, output int lat);
    logic [31:0] a;
    logic [31:0] b;
    int guard;
    a = dvd;
    b = dsr;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("in_ready_before_accept", int'(in_ready), 1);
    dividend = a[DW-1:0];
    divisor  = b[VW-1:0];
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_and_wait(v.dvd, v.dsr, lat);
    $display("op %0d / %0d -> q=%0d r=%0d dz=%0d ovf=%0d lat=%0d (exp q=%0d r=%0d dz=%0d ovf=%0d lat=%0d)",
             v.dvd, v.dsr, sq(), sr(), div_zero, ovf, lat, v.q, v.r, v.dz, v.ov, v.lat);
    chk("out_valid", int'(out_valid), 1);
    chk("latency", lat, v.lat);
    chk("quotient", sq(), v.q);
    chk("remainder", sr(), v.r);
    chk("div_zero", int'(div_zero), v.dz);
    chk("ovf", int'(ovf), v.ov);
    take_result();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_div_zero"}, int'(div_zero), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
  endtask

  vec_t tbl[16];

  initial begin
    int lat;
    tbl[0]  = '{  35,  5,    7,  0, 0, 0, LAT_N};
    tbl[1]  = '{  -7,  2,   -3, -1, 0, 0, LAT_N};
    tbl[2]  = '{   7, -2,   -3,  1, 0, 0, LAT_N};
    tbl[3]  = '{  -8, -3,    2, -2, 0, 0, LAT_N};
    tbl[4]  = '{-128, -1, -128,  0, 0, 1, LAT_N};
    tbl[5]  = '{   5,  0,   -1,  0, 1, 0, LAT_Z};
    tbl[6]  = '{ 127,  7,   18,  1, 0, 0, LAT_N};
    tbl[7]  = '{-128,  7,  -18, -2, 0, 0, LAT_N};
    tbl[8]  = '{-128, -8,   16,  0, 0, 0, LAT_N};
    tbl[9]  = '{ 100, -8,  -12,  4, 0, 0, LAT_N};
    tbl[10] = '{   0,  3,    0,  0, 0, 0, LAT_N};
    tbl[11] = '{  -1,  1,   -1,  0, 0, 0, LAT_N};
    tbl[12] = '{-128,  1, -128,  0, 0, 0, LAT_N};
    tbl[13] = '{ 127, -1, -127,  0, 0, 0, LAT_N};
    tbl[14] = '{   0,  0,   -1,  0, 1, 0, LAT_Z};
    tbl[15] = '{ -93,  7,  -13, -2, 0, 0, LAT_N};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(tbl[i]);

    // Back-pressure: result held while out_ready=0, new operands ignored.
    start_and_wait(35, 5, lat);
    chk("bp_latency", lat, LAT_N);
    dividend = 8'd6;
    divisor  = 4'd2;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_quotient", sq(), 7);
      chk("bp_remainder", sr(), 0);
    end
    $display("backpressure hold done q=%0d r=%0d", sq(), sr());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_after_hs_in_ready", int'(in_ready), 1);
    chk("bp_after_hs_out_valid", int'(out_valid), 0);
    // in_valid still high: accepted at this next edge.
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", int'(in_ready), 0);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    $display("backpressure second op 6 / 2 -> q=%0d r=%0d lat=%0d", sq(), sr(), lat);
    chk("bp_second_latency", lat, LAT_N);
    chk("bp_second_quotient", sq(), 3);
    chk("bp_second_remainder", sr(), 0);
    take_result();

    // Reset in the middle of CALC.
    dividend = 8'd127;
    divisor  = 4'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("midreset_out_valid_held", int'(out_valid), 0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("aborted_no_out_valid", int'(out_valid), 0);
    end
    $display("reset mid-operation: outputs returned to reset values");
    run_vec('{6, 2, 3, 0, 0, 0, LAT_N});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
